// File: rtl/adau_spi_pkg.sv
// Shared types and constants for the ADAU codec SPI register sequencer.
// The READBACK_VERIFY_EN macro is consumed by adau_spi_sequencer, not here.
package adau_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUMMY,
    ST_FETCH,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_GAP,
    ST_FINISH
  } seq_state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_LEAD,
    PH_LOW,
    PH_HIGH,
    PH_TRAIL
  } shift_phase_t;

  localparam logic [7:0]  CMD_WRITE  = 8'h00;
  localparam logic [7:0]  CMD_READ   = 8'h01;
  localparam logic [15:0] END_MARKER = 16'hFFFF;

  function automatic logic is_end_marker(input logic [15:0] addr);
    return (addr == END_MARKER);
  endfunction

endpackage

// File: rtl/adau_spi_shifter.sv
// SPI mode-3 frame serialiser: cs_n lead/trail of CLK_DIV cycles around the clock burst,
// mosi launched on sclk falling edges, miso captured on rising edges.
module adau_spi_shifter
  import adau_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 32,
  parameter int RX_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  go,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  output logic [RX_BITS-1:0]    rx_data,
  output logic                  frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  shift_phase_t          phase_r;
  logic [DIV_W-1:0]      div_cnt_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [FRAME_BITS-1:0] shreg_r;
  logic                  div_end_s;

  assign div_end_s = (div_cnt_r == DIV_LAST);

  // Frame phase machine; reset forces the bus idle at once, abandoning any frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r    <= PH_IDLE;
      div_cnt_r  <= '0;
      bit_cnt_r  <= '0;
      shreg_r    <= '0;
      sclk       <= 1'b1;
      cs_n       <= 1'b1;
      mosi       <= 1'b0;
      rx_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (phase_r != PH_IDLE) begin
        div_cnt_r <= div_end_s ? '0 : div_cnt_r + DIV_W'(1);
      end else begin
        div_cnt_r <= '0;
      end
      case (phase_r)
        PH_IDLE: begin
          if (load) shreg_r <= tx_data;
          if (go) begin
            cs_n      <= 1'b0;
            bit_cnt_r <= '0;
            phase_r   <= PH_LEAD;
          end
        end
        PH_LEAD, PH_HIGH: begin
          if (div_end_s) begin
            sclk    <= 1'b0;
            mosi    <= shreg_r[FRAME_BITS-1];
            shreg_r <= {shreg_r[FRAME_BITS-2:0], 1'b0};
            phase_r <= PH_LOW;
          end
        end
        PH_LOW: begin
          if (div_end_s) begin
            sclk      <= 1'b1;
            rx_data   <= {rx_data[RX_BITS-2:0], miso};
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            phase_r   <= (bit_cnt_r == BIT_LAST) ? PH_TRAIL : PH_HIGH;
          end
        end
        PH_TRAIL: begin
          if (div_end_s) begin
            cs_n       <= 1'b1;
            frame_done <= 1'b1;
            phase_r    <= PH_IDLE;
          end
        end
        default: begin
          sclk    <= 1'b1;
          cs_n    <= 1'b1;
          phase_r <= PH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/adau_spi_sequencer.sv
// Walks a register table into the codec over SPI after N_DUMMY mode-latching frames.
// Define READBACK_VERIFY_EN to read back and compare every written register.
module adau_spi_sequencer
  import adau_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_BYTES = 1,
  parameter int N_DUMMY    = 3,
  parameter int N_ENTRIES  = 16,
  parameter int CS_GAP     = 4,
  localparam int IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [IDX_W-1:0]          err_index,
  output logic [IDX_W-1:0]          tbl_index,
  input  logic [16+8*DATA_BYTES-1:0] tbl_entry,
  output logic                      sclk,
  output logic                      cs_n,
  output logic                      mosi,
  input  logic                      miso
);

  localparam int DW         = 8 * DATA_BYTES;
  localparam int FRAME_BITS = 24 + DW;
  localparam int DCW        = (N_DUMMY > 1) ? $clog2(N_DUMMY) : 1;
  localparam int GW         = $clog2(CS_GAP + 2);

  seq_state_t            state_r;
  seq_state_t            ret_r;
  logic                  launched_r;
  logic                  fetch_wait_r;
  logic [DCW-1:0]        dummy_cnt_r;
  logic [GW-1:0]         gap_cnt_r;
  logic [15:0]           addr_r;
  logic [DW-1:0]         data_r;
  logic [DW-1:0]         rd_data_r;
  logic [FRAME_BITS-1:0] tx_r;
  logic                  load_r;
  logic                  go_r;
  logic [DW-1:0]         rx_data_s;
  logic                  frame_done_s;
  logic                  last_entry_s;

  assign last_entry_s = (tbl_index == IDX_W'(N_ENTRIES - 1));

  adau_spi_shifter #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS),
    .RX_BITS    (DW)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (load_r),
    .tx_data    (tx_r),
    .go         (go_r),
    .miso       (miso),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .rx_data    (rx_data_s),
    .frame_done (frame_done_s)
  );

  // Sequencer FSM; each frame state launches once, then waits for the shifter to finish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ret_r        <= ST_IDLE;
      launched_r   <= 1'b0;
      fetch_wait_r <= 1'b0;
      dummy_cnt_r  <= '0;
      gap_cnt_r    <= '0;
      addr_r       <= 16'h0000;
      data_r       <= '0;
      rd_data_r    <= '0;
      tx_r         <= '0;
      load_r       <= 1'b0;
      go_r         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_index    <= '0;
      tbl_index    <= '0;
    end else begin
      load_r <= 1'b0;
      go_r   <= 1'b0;
      done   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            error        <= 1'b0;
            err_index    <= '0;
            tbl_index    <= '0;
            dummy_cnt_r  <= '0;
            launched_r   <= 1'b0;
            fetch_wait_r <= 1'b0;
            state_r      <= (N_DUMMY > 0) ? ST_DUMMY : ST_FETCH;
          end
        end
        ST_DUMMY: begin
          if (!launched_r) begin
            tx_r       <= '0;
            load_r     <= 1'b1;
            go_r       <= 1'b1;
            launched_r <= 1'b1;
          end else if (frame_done_s) begin
            launched_r <= 1'b0;
            gap_cnt_r  <= GW'(1);
            state_r    <= ST_GAP;
            if (dummy_cnt_r == DCW'(N_DUMMY - 1)) begin
              ret_r <= ST_FETCH;
            end else begin
              ret_r       <= ST_DUMMY;
              dummy_cnt_r <= dummy_cnt_r + DCW'(1);
            end
          end
        end
        ST_FETCH: begin
          // The table is a synchronous read, so wait one cycle after tbl_index settles.
          if (!fetch_wait_r) begin
            fetch_wait_r <= 1'b1;
          end else begin
            fetch_wait_r <= 1'b0;
            addr_r       <= tbl_entry[DW +: 16];
            data_r       <= tbl_entry[DW-1:0];
            state_r      <= is_end_marker(tbl_entry[DW +: 16]) ? ST_FINISH : ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!launched_r) begin
            tx_r       <= {CMD_WRITE, addr_r, data_r};
            load_r     <= 1'b1;
            go_r       <= 1'b1;
            launched_r <= 1'b1;
          end else if (frame_done_s) begin
            launched_r <= 1'b0;
            gap_cnt_r  <= GW'(1);
            state_r    <= ST_GAP;
`ifdef READBACK_VERIFY_EN
            ret_r      <= ST_READ;
`else
            if (last_entry_s) begin
              ret_r <= ST_FINISH;
            end else begin
              ret_r     <= ST_FETCH;
              tbl_index <= tbl_index + IDX_W'(1);
            end
`endif
          end
        end
        ST_READ: begin
          if (!launched_r) begin
            tx_r       <= {CMD_READ, addr_r, {DW{1'b0}}};
            load_r     <= 1'b1;
            go_r       <= 1'b1;
            launched_r <= 1'b1;
          end else if (frame_done_s) begin
            launched_r <= 1'b0;
            rd_data_r  <= rx_data_s;
            state_r    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (rd_data_r != data_r) begin
            error     <= 1'b1;
            err_index <= tbl_index;
            state_r   <= ST_FINISH;
          end else begin
            gap_cnt_r <= GW'(1);
            state_r   <= ST_GAP;
            if (last_entry_s) begin
              ret_r <= ST_FINISH;
            end else begin
              ret_r     <= ST_FETCH;
              tbl_index <= tbl_index + IDX_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_r >= GW'(CS_GAP)) begin
            state_r <= ret_r;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        ST_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/adau_spi_sequencer.md
ADAU_SPI_SEQUENCER -- requirements
Module: adau_spi_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (>=1).
REQ-002 SHALL have parameter DATA_BYTES, default 1, meaning data bytes per register frame (1..6).
REQ-003 SHALL have parameter N_DUMMY, default 3, meaning dummy frames issued before the table to latch codec SPI mode.
REQ-004 SHALL have parameter N_ENTRIES, default 16, meaning table entries walked per start.
REQ-005 SHALL have parameter CS_GAP, default 4, meaning minimum clk cycles cs_n held high between frames.
REQ-006 Ports, clock and reset first:
 clk  in  1  single system clock; all logic on rising edge.
 reset  in  1  asynchronous, active-high reset.
 start  in  1  one-cycle pulse, begins sequence when idle.
 busy  out  1  high from accepted start until done/error.
 done  out  1  one-cycle pulse, sequence complete.
 error  out  1  sticky; cleared by next accepted start.
 err_index  out  clog2(N_ENTRIES)  table index of first failure.
 tbl_index  out  clog2(N_ENTRIES)  table read address.
 tbl_entry  in  16+8*DATA_BYTES  {reg_addr[15:0], data}; valid one cycle after tbl_index.
 sclk  out  1  SPI clock, idle high.
 cs_n  out  1  SPI chip select, active low.
 mosi  out  1  SPI data to codec.
 miso  in  1  SPI data from codec.

Function
REQ-007 Frame SHALL be: 8-bit command (0x00 write, 0x01 read), 16-bit reg_addr, 8*DATA_BYTES data, MSB first.
REQ-008 mosi SHALL change on sclk falling edge; miso SHALL be sampled on sclk rising edge.
REQ-009 cs_n SHALL fall CLK_DIV cycles before the first sclk falling edge and rise CLK_DIV cycles after the last rising edge.
REQ-010 Each frame SHALL produce exactly 24+8*DATA_BYTES sclk rising edges; sclk SHALL stay high while cs_n is high.
REQ-011 States: IDLE, DUMMY, FETCH, WRITE, READ, CHECK, GAP, FINISH.
REQ-012 IDLE -> DUMMY on start; N_DUMMY frames each as a write of all-zero content, separated by GAP.
REQ-013 After dummies: FETCH (drive tbl_index, wait 1 cycle) -> WRITE -> GAP -> next FETCH; tbl_index increments 0..N_ENTRIES-1.
REQ-014 After the last entry: FINISH pulses done one cycle, then IDLE; busy falls in the same cycle done pulses.
REQ-015 start while busy SHALL be ignored.
REQ-016 An entry with reg_addr 0xFFFF SHALL terminate the sequence early (no frame issued) and go to FINISH.
REQ-017 Frame bit counter SHALL be sized to 24+8*DATA_BYTES; no wrap-around within a frame.

Reset
REQ-018 On reset: state IDLE, cs_n=1, sclk=1, mosi=0, busy=0, done=0, error=0, err_index=0, tbl_index=0.
REQ-019 Reset mid-frame SHALL immediately raise cs_n and sclk, aborting the frame; no partial resume.

Configuration
REQ-020 Macro READBACK_VERIFY_EN: when defined, each WRITE is followed by GAP, READ of the same reg_addr, then CHECK comparing captured data to the entry data.
REQ-021 With READBACK_VERIFY_EN, mismatch SHALL set error, latch err_index, abort remaining entries, and pulse done.
REQ-022 Without READBACK_VERIFY_EN, READ and CHECK are unreachable, miso is unused, error stays 0.

Structure
REQ-023 Shared package adau_spi_pkg SHALL hold the state enum, command constants CMD_WRITE/CMD_READ, and END_MARKER 0xFFFF.
REQ-024 Bit-level serialisation SHALL live in sub-module adau_spi_shifter (load/go in, sclk/cs_n/mosi/rx_data/frame_done out); the sequencer holds the FSM only.

Verification
REQ-025 N_DUMMY=3, CLK_DIV=2, start -> three cs_n low windows of 32 sclk rising edges each, mosi all zero, each gap >=4 cycles.
REQ-026 Entry {0x4000,0x01} -> mosi stream 0x00_4000_01 MSB first, 32 rising edges, cs_n high after.
REQ-027 N_ENTRIES=4, entry 2 = {0xFFFF,x} -> two table frames, then done pulse, busy=0, tbl_index stops at 2.
REQ-028 READBACK_VERIFY_EN, miso model returns 0x00 for write 0x01 at entry 1 -> error=1, err_index=1, done pulses, no frame for entry 2.
REQ-029 reset asserted at bit 10 of a frame -> cs_n=1 and sclk=1 same cycle, busy=0; fresh start reissues dummies from zero.
REQ-030 start pulsed while busy -> no effect on state, frame count, or tbl_index.
